// File: rtl/paillier_result_packer.sv
// Collects N K-bit Paillier result words, then streams them out as W-bit beats
// (word 0 / beat 0 first) over a valid/ready interface; words arriving mid-drain are dropped.
module paillier_result_packer #(
  parameter int unsigned K = 128,
  parameter int unsigned N = 32,
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K-1:0]  in_data,
  input  logic          in_valid,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [15:0]   done_cnt
);

  localparam int unsigned B  = K / W;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_word_q, rd_word_d;
  logic [BW-1:0]   rd_beat_q, rd_beat_d;
  logic            m_valid_q, m_valid_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     done_q, done_d;
  logic            wr_en;
  logic            xfer;
  logic            last_beat;
  logic            drop;

  logic [K-1:0]    buf_q [N];

  assign xfer      = m_valid_q && m_ready;
  assign last_beat = (rd_word_q == AW'(N - 1)) && (rd_beat_q == BW'(B - 1));
  assign drop      = in_valid && (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_word_d = rd_word_q;
    rd_beat_d = rd_beat_q;
    done_d    = done_q;
    wr_en     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == AW'(N - 1)) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (last_beat) begin
            rd_word_d = '0;
            rd_beat_d = '0;
            state_d   = COLLECT;
            done_d    = done_q + 16'd1;
          end else if (rd_beat_q == BW'(B - 1)) begin
            rd_beat_d = '0;
            rd_word_d = rd_word_q + 1'b1;
          end else begin
            rd_beat_d = rd_beat_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    // A drop in the same cycle as a clear must leave the flag set
    ovf_d     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    m_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      wr_cnt_q  <= '0;
      rd_word_q <= '0;
      rd_beat_q <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_word_q <= rd_word_d;
      rd_beat_q <= rd_beat_d;
      m_valid_q <= m_valid_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_cnt_q] <= in_data;
  end

  // Beat mux is driven from registered pointers, so it holds while m_ready is low
  assign m_data   = m_valid_q ? buf_q[rd_word_q][rd_beat_q*W +: W] : '0;
  assign m_last   = m_valid_q && last_beat;
  assign m_valid  = m_valid_q;
  assign busy     = (state_q == DRAIN) || (wr_cnt_q != '0);
  assign ovf      = ovf_q;
  assign done_cnt = done_q;

endmodule

// File: tb/tb_paillier_result_packer.sv
// Directed bench for paillier_result_packer (K=128, N=32, W=32): beat order,
// stall stability, overflow flag behaviour, mid-operation reset and gapped input.
module tb_paillier_result_packer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  in_data;
  logic          in_valid;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          ovf;
  logic          ovf_clr;
  logic [15:0]   done_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_stall = 0;
  bit          rdy_alt = 1'b0;

  logic [31:0] q_data [$];
  bit          q_last [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  paillier_result_packer #(.K(128), .N(32), .W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // m_ready driver: constant 1 or toggling each cycle
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_alt ? ~m_ready : 1'b1;
    end
  end

  // Output monitor: captures transfers and checks stability across stalls
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_stall++;
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Send n words, each followed by 'gap' idle cycles; a5 selects the 0xA5 pattern
  task automatic send(input int n, input int gap, input bit a5);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = a5 ? {4{32'hA5A5A5A5}} : 128'(i + 1);
      step();
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (c < 2000 && !(q_data.size() >= 128 && !busy && !m_valid)) begin
      step();
      c++;
    end
    chk({tag, "_drain_done"}, {31'd0, (c < 2000)}, 32'd1);
  endtask

  task automatic verify(input string tag, input bit a5);
    logic [31:0] e;
    int unsigned mism;
    int unsigned lmism;
    chk({tag, "_nbeats"}, q_data.size(), 32'd128);
    mism = 0;
    lmism = 0;
    for (int k = 0; k < 128 && k < q_data.size(); k++) begin
      if (a5)              e = 32'hA5A5A5A5;
      else if (k % 4 == 0) e = 32'(k / 4 + 1);
      else                 e = 32'd0;
      if (q_data[k] !== e) begin
        mism++;
        if (mism <= 4) chk({tag, "_beat"}, q_data[k], e);
      end
      if (q_last[k] != (k == 127)) begin
        lmism++;
        if (lmism <= 4) chk({tag, "_last"}, {31'd0, q_last[k]}, {31'd0, (k == 127)});
      end
    end
    chk({tag, "_beat_mismatches"}, mism, 32'd0);
    chk({tag, "_last_mismatches"}, lmism, 32'd0);
    if (q_data.size() > 4) begin
      chk({tag, "_beat0"}, q_data[0], a5 ? 32'hA5A5A5A5 : 32'h1);
      chk({tag, "_beat4"}, q_data[4], a5 ? 32'hA5A5A5A5 : 32'h2);
    end
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_mlast", {31'd0, m_last}, 32'd0);
    chk("rst_mdata", m_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {16'd0, done_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic: 32 back-to-back words, m_ready tied high
    send(31, 0, 1'b0);
    chk("pre_mvalid", {31'd0, m_valid}, 32'd0);
    chk("pre_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; in_data = 128'd32; step(); in_valid = 1'b0;
    chk("first_mvalid", {31'd0, m_valid}, 32'd1);
    wait_drain("basic");
    verify("basic", 1'b0);
    chk("basic_done", {16'd0, done_cnt}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_ovf", {31'd0, ovf}, 32'd0);

    // Alternating m_ready
    rdy_alt = 1'b1;
    send(32, 0, 1'b0);
    wait_drain("alt");
    rdy_alt = 1'b0;
    verify("alt", 1'b0);
    chk("alt_stalls_seen", {31'd0, (n_stall != 0)}, 32'd1);
    chk("alt_done", {16'd0, done_cnt}, 32'd2);

    // 33 consecutive words: last one dropped
    send(33, 0, 1'b0);
    chk("ovf33", {31'd0, ovf}, 32'd1);
    wait_drain("ovf33");
    verify("ovf33", 1'b0);
    chk("ovf33_done", {16'd0, done_cnt}, 32'd3);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr_alone", {31'd0, ovf}, 32'd0);
    send(32, 0, 1'b0);
    in_valid = 1'b1; in_data = '1; ovf_clr = 1'b1; step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf_clr_on_drop", {31'd0, ovf}, 32'd1);
    wait_drain("ovfclr");
    verify("ovfclr", 1'b0);
    chk("ovfclr_done", {16'd0, done_cnt}, 32'd4);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr_after", {31'd0, ovf}, 32'd0);

    // Reset mid-collection
    send(10, 0, 1'b0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {16'd0, done_cnt}, 32'd0);
    step(); rst_n = 1'b1; step();

    // Reset mid-drain: no residual beats afterwards
    send(32, 0, 1'b0);
    repeat (5) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    q_data.delete(); q_last.delete();
    repeat (10) step();
    chk("drainrst_beats", q_data.size(), 32'd0);
    chk("drainrst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("drainrst_busy", {31'd0, busy}, 32'd0);

    send(32, 0, 1'b1);
    wait_drain("a5");
    verify("a5", 1'b1);
    chk("a5_done", {16'd0, done_cnt}, 32'd1);

    // Gapped input, one cycle in three
    send(32, 2, 1'b0);
    wait_drain("gap");
    verify("gap", 1'b0);
    chk("gap_done", {16'd0, done_cnt}, 32'd2);
    chk("gap_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paillier_result_packer.md
PAILLIER_RESULT_PACKER -- requirements
Module: paillier_result_packer

Interface
REQ-001 The module SHALL have parameter K, default 128, giving the width of one result word.
REQ-002 The module SHALL have parameter N, default 32, giving the number of result words per ciphertext.
REQ-003 The module SHALL have parameter W, default 32, giving the output beat width; K SHALL be an integer multiple of W, and B = K/W denotes beats per word.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  K  result word from the Paillier core's enc_out_data, least-significant word first.
REQ-007 in_valid  input  1  in_data is valid this cycle; there is no backpressure toward the core.
REQ-008 m_data  output  W  output beat.
REQ-009 m_valid  output  1  m_data is valid.
REQ-010 m_ready  input  1  downstream accepts the beat when m_valid is also high.
REQ-011 m_last  output  1  marks the final beat of a ciphertext.
REQ-012 busy  output  1  collection in progress or drain pending.
REQ-013 ovf  output  1  sticky flag: an input word was dropped.
REQ-014 ovf_clr  input  1  clears ovf.
REQ-015 done_cnt  output  16  count of fully drained ciphertexts.

Function
REQ-016 The block SHALL implement two states: COLLECT (reset state) and DRAIN.
REQ-017 In COLLECT, each cycle with in_valid high SHALL store in_data into buffer[wr_cnt] and increment wr_cnt.
REQ-018 When in_valid is high and wr_cnt == N-1, the block SHALL store the word, set wr_cnt to 0, and enter DRAIN on the next cycle.
REQ-019 m_valid SHALL be registered, low in COLLECT, and high in every DRAIN cycle, first asserting the cycle after the Nth word is accepted.
REQ-020 In DRAIN, m_data SHALL equal bits [rd_beat*W +: W] of buffer[rd_word], with order word 0 beat 0 first, least-significant beat first within a word.
REQ-021 A transfer SHALL occur when m_valid && m_ready; on a transfer rd_beat increments, and on rd_beat == B-1 it wraps to 0 and rd_word increments.
REQ-022 While m_ready is low, m_data, m_last and m_valid SHALL hold stable.
REQ-023 m_last SHALL be high only when rd_word == N-1 and rd_beat == B-1.
REQ-024 The transfer of the m_last beat SHALL clear rd_word and rd_beat, return to COLLECT on the next cycle, and increment done_cnt, wrapping 0xFFFF to 0.
REQ-025 in_valid high during DRAIN SHALL drop the word (no buffer write) and set ovf; this includes the cycle immediately after the Nth word.
REQ-026 ovf_clr SHALL clear ovf; if ovf_clr coincides with a drop, ovf SHALL be 1.
REQ-027 busy SHALL equal (state == DRAIN) || (wr_cnt != 0).

Reset
REQ-028 When rst_n is low, the block SHALL force state COLLECT, wr_cnt/rd_word/rd_beat = 0, m_valid = 0, m_last = 0, m_data = 0, busy = 0, ovf = 0 and done_cnt = 0; buffer contents are not reset.
REQ-029 Reset mid-collection or mid-drain SHALL discard the partial ciphertext, with no residual beats emitted after release.

Verification (K=128, N=32, W=32)
REQ-030 32 consecutive words, word i = i+1, with m_ready tied to 1 -> 128 beats; beat 0 = 0x00000001, beats 1-3 = 0, beat 4 = 0x00000002; m_last only on beat 127; done_cnt = 1; busy = 0 after the last beat.
REQ-031 Same stimulus with m_ready alternating 1/0 -> identical beat sequence; m_data constant through every stalled cycle.
REQ-032 in_valid held for 33 consecutive cycles -> 33rd word dropped, ovf = 1, output equals the first 32 words; ovf_clr asserted on a drop cycle -> ovf stays 1; ovf_clr alone -> ovf = 0.
REQ-033 rst_n pulsed low after 10 words -> m_valid = 0 and busy = 0; then 32 words of 0xA5..A5 -> all 128 beats = 0xA5A5A5A5.
REQ-034 32 words with in_valid gapped (one cycle in three) -> output identical to REQ-030.
